// File: rtl/counter_ctrl.sv
// Start/stop/pause counter: counts 0..TC after START, pulses DONE for the FIN cycle.
// Define COUNTER_CTRL_AUTORELOAD_EN for periodic operation (FIN restarts the run).
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSE,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        FIN  = 2'b11
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] tc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_inc;
    logic             busy;
    logic             done;

    assign q_inc = q + WIDTH'(1);

    // NOTE: all state, including tc, is written with <= so every branch sees pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            q     <= '0;
            tc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (STOP) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        tc <= LOAD_VAL;
                        q  <= '0;
                        if (LOAD_VAL != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (PAUSE) begin
                        state <= HOLD;
                    end else begin
                        // q < tc holds throughout RUN, so the increment can never wrap.
                        q <= q_inc;
                        if (q_inc == tc) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!PAUSE) begin
                        state <= RUN;
                    end
                end
                FIN: begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
                    // A zero terminal count has a one-cycle period: stay in FIN.
                    if (tc != '0) begin
                        state <= RUN;
                        q     <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    done  <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign Q     = q;
    assign BUSY  = busy;
    assign DONE  = done;
    assign STATE = state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl; honours COUNTER_CTRL_AUTORELOAD_EN.
module tb_counter_ctrl;

    localparam int WIDTH = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_FIN  = 2'b11;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             PAUSE = 1'b0;
    logic [WIDTH-1:0] LOAD_VAL = '0;
    logic [WIDTH-1:0] Q;
    logic             BUSY;
    logic             DONE;
    logic [1:0]       STATE;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .STOP     (STOP),
        .PAUSE    (PAUSE),
        .LOAD_VAL (LOAD_VAL),
        .Q        (Q),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .STATE    (STATE)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #3;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_no_clock: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        START = 1'b1;
        LOAD_VAL = 4'd7;
        step();
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_held: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        START = 1'b0;
        RESET = 1'b0;
        step();
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
    endtask

    // After the FIN cycle: IDLE holding TC, or (autoreload) a fresh run that STOP then ends.
    task automatic finish_run(input string name, input logic [WIDTH-1:0] tc);
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        logic [1:0] es = (tc == 4'd0) ? S_FIN : S_RUN;
        logic       ed = (tc == 4'd0);
        step();
        if ({STATE, Q, BUSY, DONE} !== {es, 4'd0, ~ed, ed}) begin
            failures++;
            $display("FAIL %s_reload: got state=%0d q=%0d busy=%b done=%b, want state=%0d q=0 busy=%b done=%b",
                     name, STATE, Q, BUSY, DONE, es, ~ed, ed);
        end
        checks++;
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s_stop: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     name, STATE, Q, BUSY, DONE);
        end
        checks++;
`else
        for (int i = 0; i < 2; i++) begin
            step();
            if ({STATE, Q, BUSY, DONE} !== {S_IDLE, tc, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL %s_idle%0d: got state=%0d q=%0d busy=%b done=%b, want state=0 q=%0d busy=0 done=0",
                         name, i, STATE, Q, BUSY, DONE, tc);
            end
            checks++;
        end
`endif
    endtask

    // Plain run from START to FIN; LOAD_VAL is scrambled after START to prove TC was latched.
    task automatic test_count(input string name, input logic [WIDTH-1:0] tc);
        int dones = 0;
        LOAD_VAL = tc;
        START = 1'b1;
        step();
        START = 1'b0;
        LOAD_VAL = ~tc;
        if ({STATE, Q, BUSY, DONE} !== {S_RUN, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s_start: got state=%0d q=%0d busy=%b done=%b, want state=1 q=0 busy=1 done=0",
                     name, STATE, Q, BUSY, DONE);
        end
        checks++;
        for (int n = 1; n <= int'(tc); n++) begin
            logic [1:0] es = (n == int'(tc)) ? S_FIN : S_RUN;
            logic       ed = (n == int'(tc));
            step();
            dones += int'(DONE);
            if ({STATE, Q, BUSY, DONE} !== {es, WIDTH'(n), ~ed, ed}) begin
                failures++;
                $display("FAIL %s_edge%0d: got state=%0d q=%0d busy=%b done=%b, want state=%0d q=%0d busy=%b done=%b",
                         name, n, STATE, Q, BUSY, DONE, es, n, ~ed, ed);
            end
            checks++;
        end
        if (dones !== 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d pulses, want 1", name, dones);
        end
        checks++;
        finish_run(name, tc);
    endtask

    // TC=8, PAUSE sampled high on edges 4 and 5; edge 6 resumes RUN without counting,
    // so Q sits at 3 for three extra cycles and DONE lands on edge 11 instead of 8.
    task automatic test_pause();
        int         exp_q [11] = '{1, 2, 3, 3, 3, 3, 4, 5, 6, 7, 8};
        logic [1:0] exp_s [11] = '{S_RUN, S_RUN, S_RUN, S_HOLD, S_HOLD, S_RUN,
                                   S_RUN, S_RUN, S_RUN, S_RUN, S_FIN};
        int         done_edge = 0;
        LOAD_VAL = 4'd8;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            logic ed = (exp_s[e-1] == S_FIN);
            PAUSE = (e == 4 || e == 5);
            step();
            if (DONE === 1'b1) done_edge = e;
            if ({STATE, Q, BUSY, DONE} !== {exp_s[e-1], WIDTH'(exp_q[e-1]), ~ed, ed}) begin
                failures++;
                $display("FAIL pause_edge%0d: got state=%0d q=%0d busy=%b done=%b, want state=%0d q=%0d busy=%b done=%b",
                         e, STATE, Q, BUSY, DONE, exp_s[e-1], exp_q[e-1], ~ed, ed);
            end
            checks++;
        end
        PAUSE = 1'b0;
        if (done_edge !== 8 + 3) begin
            failures++;
            $display("FAIL pause_done_delay: got DONE at edge %0d, want edge 11", done_edge);
        end
        checks++;
        finish_run("pause", 4'd8);
    endtask

    task automatic test_stop();
        LOAD_VAL = 4'd10;
        START = 1'b1;
        step();
        for (int e = 1; e <= 4; e++) begin
            START = (e == 2 || e == 3);
            LOAD_VAL = START ? 4'd3 : 4'd10;
            step();
            if ({STATE, Q, BUSY, DONE} !== {S_RUN, WIDTH'(e), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL stop_run_edge%0d: got state=%0d q=%0d busy=%b done=%b, want state=1 q=%0d busy=1 done=0",
                         e, STATE, Q, BUSY, DONE, e);
            end
            checks++;
        end
        START = 1'b0;
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_at_4: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        step();
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_idle_hold: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        // STOP on the edge that would reach the terminal count suppresses DONE.
        LOAD_VAL = 4'd2;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_at_terminal: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        // STOP outranks PAUSE while in HOLD.
        LOAD_VAL = 4'd5;
        START = 1'b1;
        step();
        START = 1'b0;
        PAUSE = 1'b1;
        step();
        if ({STATE, Q, BUSY, DONE} !== {S_HOLD, 4'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL stop_hold_entry: got state=%0d q=%0d busy=%b done=%b, want state=2 q=0 busy=1 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        PAUSE = 1'b0;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL stop_over_pause: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        LOAD_VAL = 4'd6;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        step();
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset_mid_run: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_zero_load();
        LOAD_VAL = 4'd0;
        START = 1'b1;
        step();
        START = 1'b0;
        if ({STATE, Q, BUSY, DONE} !== {S_FIN, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL zero_load_fin: got state=%0d q=%0d busy=%b done=%b, want state=3 q=0 busy=0 done=1",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
        finish_run("zero_load", 4'd0);
    endtask

`ifdef COUNTER_CTRL_AUTORELOAD_EN
    task automatic test_autoreload();
        int dones = 0;
        LOAD_VAL = 4'd3;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            logic [1:0] es = (e % 4 == 3) ? S_FIN : S_RUN;
            logic       ed = (e % 4 == 3);
            step();
            dones += int'(DONE);
            if ({STATE, Q, BUSY, DONE} !== {es, WIDTH'(e % 4), ~ed, ed}) begin
                failures++;
                $display("FAIL reload_edge%0d: got state=%0d q=%0d busy=%b done=%b, want state=%0d q=%0d busy=%b done=%b",
                         e, STATE, Q, BUSY, DONE, es, e % 4, ~ed, ed);
            end
            checks++;
        end
        if (dones !== 3) begin
            failures++;
            $display("FAIL reload_done_count: got %0d pulses, want 3", dones);
        end
        checks++;
        STOP = 1'b1;
        step();
        STOP = 1'b0;
        if ({STATE, Q, BUSY, DONE} !== {S_IDLE, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reload_stop: got state=%0d q=%0d busy=%b done=%b, want state=0 q=0 busy=0 done=0",
                     STATE, Q, BUSY, DONE);
        end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_count("count5", 4'd5);
        test_count("count15", 4'd15);
        test_count("count1", 4'd1);
        test_pause();
        test_stop();
        test_async_reset();
        test_zero_load();
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
